regfile_dump_unit: RTL
======================

Name: regfile_dump_unit

Overview:
- Sequential reader for the 32x64 register file. On command it walks a register index range through one spare read port (RA/BusA) and streams each value out on a valid/ready handshake.
- Used for debug dumps, context save and testbench state comparison.
- Sits beside the datapath and asserts Freeze so the CPU holds off register writes while the dump runs.

Parameters:
- FIRST_REG, 0, first register index dumped (0..31).
- LAST_REG, 30, last register index dumped (FIRST_REG..31). Index 31 always reads as zero.
- DATA_WIDTH, 64, register width in bits.

Ports:
- Clk  in  1  system clock; all state updates on the posedge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle request to begin a dump. Sampled only in IDLE.
- Abort  in  1  synchronous cancel. Returns to IDLE, no Done.
- RA  out  5  read address driven to the register-file read port.
- BusA  in  DATA_WIDTH  read data returned by the register file (combinational, settles within the cycle).
- DataOut  out  DATA_WIDTH  captured register value.
- RegIdx  out  5  index of the value currently on DataOut.
- Valid  out  1  DataOut/RegIdx are valid.
- Ready  in  1  consumer accepts the word when Valid&&Ready at a posedge.
- Busy  out  1  high in any state other than IDLE.
- Freeze  out  1  equal to Busy. The CPU gates RegWr while it is high.
- Done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, high): state=IDLE, idx=FIRST_REG. RA, DataOut and RegIdx are 0. Valid, Busy, Freeze and Done are 0.
- States: IDLE, SETTLE, SEND, FINISH.
- IDLE, Start=1: idx<=FIRST_REG, RA<=FIRST_REG, go SETTLE. Start is ignored in any other state.
- SETTLE: lasts one full cycle so BusA is stable under the register file's read delay and any negedge write. At the next posedge: DataOut<=BusA, RegIdx<=idx, Valid<=1, go SEND.
- SEND: DataOut, RegIdx and Valid are held stable until the handshake. At a posedge with Ready=1:
  - if idx==LAST_REG: Valid<=0, go FINISH.
  - else: idx<=idx+1, RA<=idx+1, Valid<=0, go SETTLE.
- FINISH: Done=1 for exactly this cycle, Busy=1. The next posedge returns to IDLE.
- Latency: Start sampled at edge N gives first Valid after edge N+1. With Ready held high, throughput is one word per 2 cycles. The default range (0..30, 31 words) completes with Done asserted after edge N+62 and IDLE after edge N+63.
- Ready low stalls indefinitely in SEND with all outputs held.
- Ready high outside SEND has no effect.
- Abort (any non-IDLE state): next posedge goes to IDLE, Valid=0, Done=0. Abort takes priority over a simultaneous handshake.
- Abort in IDLE has no effect. Abort together with Start in IDLE: Abort wins, stay IDLE.
- Index 31: if LAST_REG==31, the final word is 0 (the file returns zero). No special casing in this block.
- FIRST_REG==LAST_REG: exactly one word, then Done.
- idx never wraps; it is bounded by LAST_REG.
- Reset mid-dump: immediate return to reset values. No Done, partial stream discarded.

Decomposition:
- Shared package (cpu_pkg): REG_ADDR_W=5, ZERO_REG=5'd31, DATA_W=64, dump state enum (IDLE/SETTLE/SEND/FINISH).
- Single module, no sub-modules. The index counter and FSM are small enough to stay inline.

Test Plan:
- Preload R0..R30 with 64'h1000+i, Ready=1, pulse Start -> 31 words in order, RegIdx 0..30 with DataOut 64'h1000+RegIdx. One word every 2 cycles, first Valid 2 edges after Start. Done pulses once and Busy drops the cycle after.
- Toggle Ready low for 5 cycles while Valid is high on R7 -> DataOut=64'h1007 and RegIdx=7 held stable, no skipped or duplicated words.
- FIRST_REG=30, LAST_REG=31, R30=64'hDEAD -> two words: (30, 64'hDEAD), then (31, 0). Then Done.
- Assert Abort during the R12 SEND with Ready=1 -> no handshake counted, IDLE next cycle, Valid=0, no Done. A new Start restarts from FIRST_REG.
- Assert Reset asynchronously mid-SETTLE -> all outputs 0 immediately, without waiting for a Clk edge. Start pulses during Busy are ignored; only one dump occurs.
- Testbench attempts RegWr to R5 while Freeze=1 -> the dumped R5 equals its pre-dump value.

Source files
------------

// File: rtl/regfile_dump_unit_pkg.sv
// Shared definitions for the register-file dump unit: address/data widths,
// the hard-wired zero register index and the dump sequencer state encoding.
package regfile_dump_unit_pkg;

    localparam int         REG_ADDR_W = 5;
    localparam logic [4:0] ZERO_REG   = 5'd31;
    localparam int         DATA_W     = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } dumpState_t;

endpackage

// File: rtl/regfile_dump_unit_if.sv
// Valid/ready stream carrying dumped register words (value plus index).
// The dump unit is the master; the consumer (debug port, context save) is the slave.
interface regfile_dump_unit_if #(
    parameter int DATA_WIDTH = 64
);
    import regfile_dump_unit_pkg::*;

    logic [DATA_WIDTH-1:0] DataOut;
    logic [REG_ADDR_W-1:0] RegIdx;
    logic                  Valid;
    logic                  Ready;

    modport master (
        output DataOut,
        output RegIdx,
        output Valid,
        input  Ready
    );

    modport slave (
        input  DataOut,
        input  RegIdx,
        input  Valid,
        output Ready
    );

endinterface

// File: rtl/regfile_dump_unit.sv
// Sequential register-file reader. Walks FIRST_REG..LAST_REG through a spare
// read port, giving each read a full settle cycle, and streams every value out
// on a valid/ready handshake. Freeze holds off CPU register writes while busy.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for Start; RA/DataOut keep their last values
//   SETTLE | RA is driving idx, BusA settling; captured at the next edge
//   SEND   | DataOut/RegIdx valid and held until Ready
//   FINISH | last word accepted; Done pulses for this single cycle
module regfile_dump_unit
    import regfile_dump_unit_pkg::*;
#(
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 30,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Abort,
    output logic [REG_ADDR_W-1:0]  RA,
    input  logic [DATA_WIDTH-1:0]  BusA,
    regfile_dump_unit_if.master    dumpBus,
    output logic                   Busy,
    output logic                   Freeze,
    output logic                   Done
);

    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = REG_ADDR_W'(FIRST_REG);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = REG_ADDR_W'(LAST_REG);

    dumpState_t            state;
    dumpState_t            nextState;
    logic [REG_ADDR_W-1:0] idx;
    logic [DATA_WIDTH-1:0] dataReg;
    logic [REG_ADDR_W-1:0] regIdxReg;
    logic                  loadFirst;
    logic                  capture;
    logic                  advance;

    // Next-state decode; Abort outranks both Start and a pending handshake.
    always_comb begin
        nextState = state;
        loadFirst = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !Abort) begin
                    nextState = SETTLE;
                    loadFirst = 1'b1;
                end
            end
            SETTLE: begin
                if (Abort) begin
                    nextState = IDLE;
                end else begin
                    capture   = 1'b1;
                    nextState = SEND;
                end
            end
            SEND: begin
                if (Abort) begin
                    nextState = IDLE;
                end else if (dumpBus.Ready) begin
                    if (idx == LAST_IDX) begin
                        nextState = FINISH;
                    end else begin
                        advance   = 1'b1;
                        nextState = SETTLE;
                    end
                end
            end
            FINISH: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Index counter, read address and captured word; idx stops at LAST_REG
    // because advance is never raised on the last index.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx       <= FIRST_IDX;
            RA        <= '0;
            dataReg   <= '0;
            regIdxReg <= '0;
        end else begin
            if (loadFirst) begin
                idx <= FIRST_IDX;
                RA  <= FIRST_IDX;
            end
            if (capture) begin
                dataReg   <= BusA;
                regIdxReg <= idx;
            end
            if (advance) begin
                idx <= idx + 1'b1;
                RA  <= idx + 1'b1;
            end
        end
    end

    // Valid is exactly "in SEND", so it is held through any Ready stall.
    always_comb begin
        dumpBus.DataOut = dataReg;
        dumpBus.RegIdx  = regIdxReg;
        dumpBus.Valid   = (state == SEND);
        Busy            = (state != IDLE);
        Freeze          = (state != IDLE);
        Done            = (state == FINISH);
    end

endmodule
